// File: rtl/pc_unit.sv
// pc_unit: program counter with a small return-address stack.
// Per-cycle action priority: RET > CALL > JUMP > REL > INC.
// Overflow and underflow are reported through sticky error flags.
module pc_unit #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 4,
   parameter int SP_W  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_inc,
   input  logic            s_rel,
   input  logic            s_ret,
   input  logic            enablebackup,
   input  logic [PC_W-1:0] dir_abs,
   input  logic [PC_W-1:0] dir_rel,
   output logic [PC_W-1:0] pc,
   output logic [SP_W-1:0] sp,
   output logic            stack_empty,
   output logic            stack_full,
   output logic            ovf_err,
   output logic            unf_err
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic [PC_W-1:0] stack_q [DEPTH];
   logic [PC_W-1:0] stack_d [DEPTH];

   logic            act_ret, act_call, act_jump, act_rel;
   logic            empty_w, full_w;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] stack_top;

   assign empty_w = (sp_q == '0);
   assign full_w  = (sp_q == SP_W'(DEPTH));
   assign pc_inc  = pc_q + PC_W'(1);

   // Decode the strict-priority action for this cycle
   always_comb begin
      act_ret  = s_ret;
      act_call = enablebackup & ~s_ret;
      act_jump = ~s_inc & ~s_ret & ~enablebackup;
      act_rel  = s_inc & s_rel & ~s_ret & ~enablebackup;
   end

   // Select the entry just below sp; nothing is selected when the stack is empty
   always_comb begin
      stack_top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp_q == SP_W'(i + 1)) begin
            stack_top = stack_q[i];
         end
      end
   end

   // Next-state computation for pc, sp, stack contents and error flags
   always_comb begin
      pc_d  = pc_inc;
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      for (int i = 0; i < DEPTH; i++) begin
         stack_d[i] = stack_q[i];
      end

      if (act_ret) begin
         if (empty_w) begin
            // Nothing to pop: keep executing sequentially and flag it
            pc_d  = pc_inc;
            unf_d = 1'b1;
         end else begin
            pc_d = stack_top;
            sp_d = sp_q - SP_W'(1);
         end
      end else if (act_call) begin
         pc_d = dir_abs;
         if (full_w) begin
            // The jump still happens; the return address is lost
            ovf_d = 1'b1;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (sp_q == SP_W'(i)) begin
                  stack_d[i] = pc_inc;
               end
            end
            sp_d = sp_q + SP_W'(1);
         end
      end else if (act_jump) begin
         pc_d = dir_abs;
      end else if (act_rel) begin
         pc_d = pc_q + dir_rel;
      end
   end

   // Scalar state registers, cleared immediately by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= '0;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // One register per stack entry, cleared immediately by reset
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               stack_q[gi] <= '0;
            end else begin
               stack_q[gi] <= stack_d[gi];
            end
         end
      end
   endgenerate

   assign pc          = pc_q;
   assign sp          = sp_q;
   assign stack_empty = empty_w;
   assign stack_full  = full_w;
   assign ovf_err     = ovf_q;
   assign unf_err     = unf_q;

endmodule
